// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : Read-side controller of the asynchronous FIFO (rclk domain).
//               Synchronises the Gray write pointer, keeps the binary/Gray
//               read pointers, and produces registered empty, almost-empty,
//               fill-level and underflow indications.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH    = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  i_rinc,
    input  logic [ADDR_WIDTH:0]   i_wptr_gray,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic [ADDR_WIDTH:0]   o_rptr_gray,
    output logic                  o_rempty,
    output logic                  o_raempty,
    output logic [ADDR_WIDTH:0]   o_rlevel,
    output logic                  o_runderflow
);

    localparam int               c_PW          = ADDR_WIDTH + 1;
    localparam logic [c_PW-1:0]  c_AEMPTY_LVL  = c_PW'(AEMPTY_THRESH);

    // Synchroniser chain: stage 0 samples the wclk-domain pointer.
    logic [SYNC_STAGES-1:0][c_PW-1:0] r_wsync;

    logic [c_PW-1:0] r_rbin;
    logic [c_PW-1:0] r_rgray;
    logic            r_rempty;
    logic            r_raempty;
    logic [c_PW-1:0] r_rlevel;
    logic            r_runderflow;

    logic [c_PW-1:0] w_wq_gray;
    logic [c_PW-1:0] w_wq_bin;
    logic            w_rd_en;
    logic [c_PW-1:0] w_rbin_next;
    logic [c_PW-1:0] w_rgray_next;
    logic [c_PW-1:0] w_level_next;

    assign w_wq_gray = r_wsync[SYNC_STAGES-1];

    // Shift the write pointer through the synchroniser flops, no logic between stages.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_wsync <= '0;
        end else begin
            r_wsync <= {r_wsync[SYNC_STAGES-2:0], i_wptr_gray};
        end
    end

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_wq_bin = '0;
        for (int i = 0; i < c_PW; i++) begin
            w_wq_bin[i] = ^(w_wq_gray >> i);
        end
    end

    // Next-pointer and occupancy arithmetic; a read while empty is dropped.
    always_comb begin
        w_rd_en      = i_rinc & ~r_rempty;
        w_rbin_next  = r_rbin + c_PW'(w_rd_en);
        w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
        w_level_next = w_wq_bin - w_rbin_next;
    end

    // Register pointers and status; empty is compared in Gray so it stays exact across the wrap.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin       <= '0;
            r_rgray      <= '0;
            r_rempty     <= 1'b1;
            r_raempty    <= 1'b1;
            r_rlevel     <= '0;
            r_runderflow <= 1'b0;
        end else begin
            r_rbin       <= w_rbin_next;
            r_rgray      <= w_rgray_next;
            r_rempty     <= (w_rgray_next == w_wq_gray);
            r_raempty    <= (w_level_next <= c_AEMPTY_LVL);
            r_rlevel     <= w_level_next;
            r_runderflow <= i_rinc & r_rempty;
        end
    end

    // RAM address is a direct slice of the binary pointer flop.
    assign o_raddr      = r_rbin[ADDR_WIDTH-1:0];
    assign o_rptr_gray  = r_rgray;
    assign o_rempty     = r_rempty;
    assign o_raempty    = r_raempty;
    assign o_rlevel     = r_rlevel;
    assign o_runderflow = r_runderflow;

endmodule
`default_nettype wire

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Parametrised read-side controller for the asynchronous FIFO, running entirely in the rclk domain. It synchronises the Gray-coded write pointer internally and maintains a Gray-coded read pointer for the write side. It also drives the RAM read address and produces registered empty, almost-empty, fill-level and underflow indications. It supersedes the fixed 8-entry, binary-compare read side and sits between the dual-port FIFO RAM, the write-side controller and the rclk-domain consumer.

## Interface
- ADDR_WIDTH, 3: RAM address bits; DEPTH = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2: flop stages in the wptr_gray synchroniser; legal minimum 2.
- AEMPTY_THRESH, 1: raempty is asserted while level <= AEMPTY_THRESH; legal range 0..DEPTH-1.

- rclk  input  1  read-domain clock.
- rrst_n  input  1  reset, asynchronous, active-low; clock rclk.
- rinc  input  1  read request; sampled on rising rclk.
- wptr_gray  input  ADDR_WIDTH+1  Gray write pointer from the wclk domain; changes at most one bit per wclk.
- raddr  output  ADDR_WIDTH  RAM read address = rbin[ADDR_WIDTH-1:0]; driven from a flop, no logic after it.
- rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-side synchroniser.
- rempty  output  1  registered, FIFO empty as seen in the read domain.
- raempty  output  1  registered almost-empty flag.
- rlevel  output  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
- runderflow  output  1  registered one-cycle pulse for a rejected read.

## Operation
- Synchroniser: SYNC_STAGES flops in a chain. The output of the last stage is wq_gray, and wq_bin is its Gray-to-binary conversion. No logic sits between stages.
- Read enable: rd_en = rinc & ~rempty. A rinc while empty is dropped. Pointers do not move, and runderflow pulses on the next edge.
- rbin is a binary counter of ADDR_WIDTH+1 bits. rbin_next = rbin + rd_en, modulo 2^(ADDR_WIDTH+1). It wraps naturally, and the MSB toggles once per DEPTH reads.
- rgray_next = rbin_next ^ (rbin_next >> 1). Both rbin and rptr_gray are registered from the _next values on the same edge.
- rempty <= (rgray_next == wq_gray).
- level_next = (wq_bin - rbin_next) modulo 2^(ADDR_WIDTH+1). rlevel <= level_next.
- raempty <= (level_next <= AEMPTY_THRESH).
- runderflow <= rinc & rempty.
- No state machine. Sequential state is the synchroniser chain, rbin, rptr_gray and the four registered flags/level.
- rempty and rlevel are conservative because wq_gray lags the true write pointer. The block never reports data that is not present.
- The write side guarantees wptr never leads rptr by more than DEPTH, so level_next is always at most DEPTH. The block does not check this.

## Timing
- Reset values (asynchronous, while rrst_n=0):
  - all synchroniser flops = 0;
  - rbin, rptr_gray, raddr = 0;
  - rempty = 1, raempty = 1;
  - rlevel = 0;
  - runderflow = 0.
- Reset deassertion is synchronous to rclk at the system level. The wclk-side reset is asserted over the same interval; mid-operation reset discards all content on both sides.
- Write visibility: when wptr_gray changes before rclk edge N, wq_gray reflects it after edge N+SYNC_STAGES-1. rempty, raempty and rlevel update at edge N+SYNC_STAGES, i.e. 3 edges with the default.
- Read: rinc=1 with rempty=0 at edge N means raddr, rptr_gray and rlevel advance at edge N. RAM data for the old raddr is consumed by the user on that same edge; the RAM is asynchronous-read.
- Read of the last entry: rempty rises at the same edge as the pointer update, so back-to-back reads never overrun.
- Simultaneous read and write arrival: the edge applies both. Level is unchanged if one read and one write pointer step coincide.
- Wrap-around: raddr goes from DEPTH-1 to 0. The rptr_gray MSB-side bit toggles, and empty comparison stays exact across the wrap.

## Test plan
- Reset with rinc=1 and wptr_gray=0 → rempty=1, raempty=1, rlevel=0, raddr=0, rptr_gray=0. runderflow=1 from the first edge after release while rinc stays high; it is held 0 during reset.
- wptr_gray 0→1 (binary 1) before edge 0, rinc=0 → rempty falls and rlevel=1 after edge 2 (defaults). raempty stays 1 (1 <= 1).
- Fill: wptr_gray set to Gray(8)=4'b1100, then 8 consecutive rinc → rlevel steps 8,7,…,0. raddr steps 0..7. raempty rises when rlevel reaches 1. rempty rises on the 8th read edge; a 9th rinc gives runderflow=1 for one cycle and raddr stays 0.
- Wrap: 16 writes and 16 reads interleaved → rbin wraps 15→0, and rptr_gray goes 4'b1000→4'b0000. rempty is correct throughout, with no false empty or full at the wrap.
- Simultaneous read and write: rlevel=4 and rinc=1 on the same edge as wq advancing by one → rlevel stays 4 and raddr advances by 1.
- Mid-operation reset: rlevel=5, assert rrst_n=0 between edges → all outputs take their reset values immediately, without waiting for a clock edge.
